// File: rtl/branch_resolve.sv
// branch_resolve: execute-stage branch resolution. It queues each conditional
// branch from fetch with its prediction, retires the entries in order as execute
// reports outcomes, and drives the redirect bus back to the PC/predictor.
module branch_resolve #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_valid_i,
    input  logic [ADDR_W-1:0] push_pc_i,
    input  logic [12:0]       push_imm_i,
    input  logic              push_predict_i,
    output logic              push_ready_o,
    input  logic              res_valid_i,
    input  logic              res_taken_i,
    input  logic              jal_valid_i,
    input  logic [ADDR_W-1:0] jal_from_i,
    input  logic [ADDR_W-1:0] jal_to_i,
    input  logic              irq_i,
    input  logic [ADDR_W-1:0] irq_addr_i,
    input  logic              exc_i,
    input  logic [ADDR_W-1:0] exc_addr_i,
    input  logic [ADDR_W-1:0] exc_pc_i,
    output logic [2:0]        jump_cause_o,
    output logic [ADDR_W-1:0] jump_from_addr_o,
    output logic [ADDR_W-1:0] jump_to_addr_o,
    output logic [15:0]       branch_cnt_o,
    output logic [15:0]       mispredict_cnt_o,
    output logic              underflow_o
);
    // jump_cause_bus encodings shared with the PC/predictor
    localparam logic [2:0] jump_cause_no                 = 3'd0;
    localparam logic [2:0] jump_cause_exception          = 3'd1;
    localparam logic [2:0] jump_cause_interrupt          = 3'd2;
    localparam logic [2:0] jump_cause_predict_yes_but_no = 3'd3;
    localparam logic [2:0] jump_cause_predict_no_but_yes = 3'd4;
    localparam logic [2:0] jump_cause_nocondition        = 3'd5;

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic {RUN, SQUASH} state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        cause_q, cause_d;
    logic [ADDR_W-1:0] from_q, from_d, to_q, to_d;
    logic [15:0]       bcnt_q, bcnt_d, mcnt_q, mcnt_d;
    logic              uf_q, uf_d;

    // Branch queue storage: data only, validity is tracked by the pointers/count
    logic [ADDR_W-1:0] pc_q   [DEPTH];
    logic [12:0]       imm_q  [DEPTH];
    logic              pred_q [DEPTH];

    logic              push_we;
    logic              res_acc, mispred, jal_acc, redirect;
    logic [ADDR_W-1:0] head_pc, head_imm_sx;
    logic              head_pred;

    assign head_pc      = pc_q[rd_q];
    assign head_pred    = pred_q[rd_q];
    assign head_imm_sx  = {{(ADDR_W-13){imm_q[rd_q][12]}}, imm_q[rd_q]};

    // Readiness comes from registered state only; a same-cycle pop does not free a slot
    assign push_ready_o = (cnt_q < CW'(DEPTH)) && (state_q == RUN);

    assign jump_cause_o     = cause_q;
    assign jump_from_addr_o = from_q;
    assign jump_to_addr_o   = to_q;
    assign branch_cnt_o     = bcnt_q;
    assign mispredict_cnt_o = mcnt_q;
    assign underflow_o      = uf_q;

    // Next state: queue bookkeeping, statistics and the prioritised redirect
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        cause_d = jump_cause_no;
        from_d  = from_q;
        to_d    = to_q;
        bcnt_d  = bcnt_q;
        mcnt_d  = mcnt_q;
        uf_d    = uf_q;
        push_we = 1'b0;

        // In SQUASH, resolves and jumps belong to the squashed path and are ignored
        res_acc = (state_q == RUN) && res_valid_i && (cnt_q != '0);
        mispred = res_acc && (head_pred != res_taken_i);
        jal_acc = (state_q == RUN) && jal_valid_i;

        if ((state_q == RUN) && res_valid_i && (cnt_q == '0))
            uf_d = 1'b1;

        // A resolve is retired and counted even when a higher-priority event wins
        if (res_acc) begin
            rd_d   = rd_q + PW'(1);
            bcnt_d = (bcnt_q == 16'hFFFF) ? bcnt_q : bcnt_q + 16'd1;
            if (mispred)
                mcnt_d = (mcnt_q == 16'hFFFF) ? mcnt_q : mcnt_q + 16'd1;
        end

        if (exc_i) begin
            cause_d = jump_cause_exception;
            from_d  = exc_pc_i;
            to_d    = exc_addr_i;
        end else if (irq_i) begin
            cause_d = jump_cause_interrupt;
            from_d  = exc_pc_i;
            to_d    = irq_addr_i;
        end else if (mispred) begin
            cause_d = head_pred ? jump_cause_predict_yes_but_no : jump_cause_predict_no_but_yes;
            from_d  = head_pc;
            to_d    = head_pred ? head_pc + ADDR_W'(4) : head_pc + head_imm_sx;
        end else if (jal_acc) begin
            cause_d = jump_cause_nocondition;
            from_d  = jal_from_i;
            to_d    = jal_to_i;
        end

        redirect = exc_i || irq_i || mispred || jal_acc;

        // Any redirect flushes everything, including a push offered this cycle
        if (redirect) begin
            state_d = SQUASH;
            cnt_d   = '0;
            rd_d    = wr_q;
        end else begin
            state_d = RUN;
            push_we = push_valid_i && push_ready_o;
            if (push_we)
                wr_d = wr_q + PW'(1);
            cnt_d = cnt_q + CW'(push_we) - CW'(res_acc);
        end
    end

    // Control, statistics and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            cause_q <= jump_cause_no;
            from_q  <= '0;
            to_q    <= '0;
            bcnt_q  <= '0;
            mcnt_q  <= '0;
            uf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
            from_q  <= from_d;
            to_q    <= to_d;
            bcnt_q  <= bcnt_d;
            mcnt_q  <= mcnt_d;
            uf_q    <= uf_d;
        end
    end

    // Queue payload write at the tail
    always_ff @(posedge clk) begin
        if (push_we) begin
            pc_q[wr_q]   <= push_pc_i;
            imm_q[wr_q]  <= push_imm_i;
            pred_q[wr_q] <= push_predict_i;
        end
    end

endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: directed stimulus, a queue-based reference model and a
// per-cycle compare process, plus hand-computed literal checks.
module tb_branch_resolve;
    localparam logic [2:0] C_NO = 3'd0, C_EXC = 3'd1, C_IRQ = 3'd2,
                           C_YBN = 3'd3, C_NBY = 3'd4, C_JAL = 3'd5;

    logic clk = 0, rst_n = 0;
    logic pv = 0, pp = 0, ready;
    logic [31:0] ppc = 0;
    logic [12:0] pimm = 0;
    logic rv = 0, rt = 0, jv = 0, irq = 0, exc = 0;
    logic [31:0] jfrom = 0, jto = 0, irq_addr = 0, exc_addr = 0, exc_pc = 0;
    logic [2:0]  cause;
    logic [31:0] from_a, to_a;
    logic [15:0] bc, mc;
    logic uf;

    int errors = 0, checks = 0;

    branch_resolve #(.DEPTH(4), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .push_valid_i(pv), .push_pc_i(ppc), .push_imm_i(pimm), .push_predict_i(pp),
        .push_ready_o(ready),
        .res_valid_i(rv), .res_taken_i(rt),
        .jal_valid_i(jv), .jal_from_i(jfrom), .jal_to_i(jto),
        .irq_i(irq), .irq_addr_i(irq_addr),
        .exc_i(exc), .exc_addr_i(exc_addr), .exc_pc_i(exc_pc),
        .jump_cause_o(cause), .jump_from_addr_o(from_a), .jump_to_addr_o(to_a),
        .branch_cnt_o(bc), .mispredict_cnt_o(mc), .underflow_o(uf)
    );

    always #5 clk = ~clk;

    // Reference model: in-flight branches as a plain queue
    typedef struct { logic [31:0] pc; logic [12:0] imm; logic pred; } ent_t;
    ent_t        mq[$];
    bit          m_sq;
    logic [2:0]  m_cause;
    logic [31:0] m_from, m_to;
    int          m_bc, m_mc;
    bit          m_uf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_sq = 0; m_cause = C_NO; m_from = 0; m_to = 0; m_bc = 0; m_mc = 0; m_uf = 0;
    endtask

    // Apply the current inputs to the model as one clock edge
    task automatic model_update();
        logic [2:0]  c = C_NO;
        logic [31:0] f = 0, t = 0;
        bit rdy = !m_sq && mq.size() < 4;
        if (exc)      begin c = C_EXC; f = exc_pc; t = exc_addr; end
        else if (irq) begin c = C_IRQ; f = exc_pc; t = irq_addr; end
        if (!m_sq) begin
            if (rv) begin
                if (mq.size() > 0) begin
                    ent_t h = mq.pop_front();
                    int   off = $signed(h.imm);
                    if (m_bc < 65535) m_bc++;
                    if (h.pred != rt) begin
                        if (m_mc < 65535) m_mc++;
                        if (c == C_NO) begin
                            c = h.pred ? C_YBN : C_NBY;
                            f = h.pc;
                            t = h.pred ? h.pc + 32'd4 : h.pc + off;
                        end
                    end
                end else m_uf = 1;
            end
            if (c == C_NO && jv) begin c = C_JAL; f = jfrom; t = jto; end
        end
        if (c != C_NO) begin
            mq.delete();
            m_sq = 1; m_from = f; m_to = t;
        end else begin
            m_sq = 0;
            if (rdy && pv) mq.push_back('{ppc, pimm, pp});
        end
        m_cause = c;
    endtask

    // One clock: inputs stay stable across the edge, model follows it
    task automatic step();
        @(posedge clk); #1;
        model_update();
    endtask

    task automatic idle();
        pv = 0; rv = 0; jv = 0; irq = 0; exc = 0;
    endtask

    task automatic push(input logic [31:0] pc, input logic [12:0] imm, input logic pr);
        pv = 1; ppc = pc; pimm = imm; pp = pr;
        step(); idle();
    endtask

    task automatic resolve(input logic taken);
        rv = 1; rt = taken;
        step(); idle();
    endtask

    // Compare every output against the model on the falling edge
    bit cmp_en = 0;
    always @(negedge clk) if (cmp_en) begin
        chk("cause", 32'(cause), 32'(m_cause));
        chk("from", from_a, m_from);
        chk("to", to_a, m_to);
        chk("branch_cnt", 32'(bc), 32'(m_bc));
        chk("mispredict_cnt", 32'(mc), 32'(m_mc));
        chk("underflow", 32'(uf), 32'(m_uf));
        chk("push_ready", 32'(ready), 32'(!m_sq && mq.size() < 4));
    end

    initial begin
        model_reset();
        #12 rst_n = 1;
        cmp_en = 1;
        @(posedge clk); #1;
        chk("lit_reset_ready", 32'(ready), 32'd1);
        chk("lit_reset_cause", 32'(cause), 32'(C_NO));

        // Mispredict not-taken -> taken
        push(32'h100, 13'h020, 1'b0);
        resolve(1'b1);
        chk("lit_nby_cause", 32'(cause), 32'(C_NBY));
        chk("lit_nby_from", from_a, 32'h100);
        chk("lit_nby_to", to_a, 32'h120);
        chk("lit_nby_mc", 32'(mc), 32'd1);
        chk("lit_nby_bc", 32'(bc), 32'd1);
        chk("lit_squash_ready", 32'(ready), 32'd0);
        step();
        chk("lit_after_cause", 32'(cause), 32'(C_NO));
        chk("lit_after_to_hold", to_a, 32'h120);

        // Mispredict taken -> not-taken, fall-through wraps
        push(32'hFFFF_FFFC, 13'h008, 1'b1);
        resolve(1'b0);
        chk("lit_ybn_cause", 32'(cause), 32'(C_YBN));
        chk("lit_ybn_to", to_a, 32'h0);
        step();

        // Negative offset, taken mispredict
        push(32'h400, 13'h1FF0, 1'b0);
        resolve(1'b1);
        chk("lit_neg_to", to_a, 32'h3F0);
        step();

        // Fill the queue, refused fifth push alongside a resolve, drain
        for (int i = 0; i < 4; i++) push(32'h1000 + 32'(i * 4), 13'h010, 1'b1);
        chk("lit_full_ready", 32'(ready), 32'd0);
        pv = 1; ppc = 32'h2000; pimm = 13'h010; pp = 1'b0;
        rv = 1; rt = 1;
        step(); idle();
        for (int i = 0; i < 3; i++) resolve(1'b1);
        chk("lit_drain_bc", 32'(bc), 32'd7);
        chk("lit_drain_cause", 32'(cause), 32'(C_NO));

        // Exception wins over mispredict and jal; resolve still counted
        push(32'h300, 13'h040, 1'b0);
        rv = 1; rt = 1; jv = 1; jfrom = 32'h10; jto = 32'h20;
        exc = 1; exc_addr = 32'h80; exc_pc = 32'h200;
        step(); idle();
        chk("lit_exc_cause", 32'(cause), 32'(C_EXC));
        chk("lit_exc_from", from_a, 32'h200);
        chk("lit_exc_to", to_a, 32'h80);
        chk("lit_exc_mc", 32'(mc), 32'd4);
        step();

        // Empty-queue resolve sets sticky underflow
        resolve(1'b1);
        chk("lit_uf", 32'(uf), 32'd1);
        step();
        chk("lit_uf_sticky", 32'(uf), 32'd1);

        // Interrupt, then an exception during SQUASH re-triggers
        irq = 1; irq_addr = 32'h40; exc_pc = 32'h500;
        step(); idle();
        chk("lit_irq_cause", 32'(cause), 32'(C_IRQ));
        exc = 1; exc_addr = 32'h88;
        rv = 1; jv = 1;
        step(); idle();
        chk("lit_retrig_cause", 32'(cause), 32'(C_EXC));
        chk("lit_retrig_to", to_a, 32'h88);
        step();

        // Plain jal redirect, then async reset in the middle of SQUASH
        jv = 1; jfrom = 32'h600; jto = 32'h700;
        step(); idle();
        chk("lit_jal_cause", 32'(cause), 32'(C_JAL));
        #2 rst_n = 0;
        #1;
        chk("lit_async_cause", 32'(cause), 32'(C_NO));
        chk("lit_async_to", to_a, 32'h0);
        chk("lit_async_bc", 32'(bc), 32'd0);
        chk("lit_async_uf", 32'(uf), 32'd0);
        chk("lit_async_ready", 32'(ready), 32'd1);
        model_reset();
        @(negedge clk); rst_n = 1;
        #3;

        // Saturate branch_cnt with correctly predicted push+resolve pairs
        push(32'h800, 13'h004, 1'b0);
        pv = 1; ppc = 32'h800; pimm = 13'h004; pp = 1'b0; rv = 1; rt = 0;
        for (int i = 0; i < 65537; i++) step();
        idle();
        chk("lit_sat_bc", 32'(bc), 32'hFFFF);
        resolve(1'b0);
        chk("lit_sat_hold", 32'(bc), 32'hFFFF);
        chk("lit_sat_mc", 32'(mc), 32'd0);
        step();

        cmp_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
